// File: rtl/dec2hex_pkg.sv
// ============================================================================
// dec2hex_pkg : shared types and constants for the decimal-to-binary entry block
// Revision    : 1.0
// ============================================================================
`default_nettype none

package dec2hex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CALC    = 2'd2,
      ST_OUT     = 2'd3
   } state_t;

   localparam int         MAX_DIGITS_DEF = 3;
   localparam logic [3:0] DEC_BASE       = 4'd10;

endpackage

`default_nettype wire

// File: rtl/dec2hex_mac.sv
// ============================================================================
// dec2hex_mac : acc*10 + digit using shift-add, with saturation detection
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dec2hex_mac
   import dec2hex_pkg::*;
#(
   parameter int HEX_W = 8
) (
   input  logic [HEX_W+1:0] acc_i,
   input  logic [3:0]       digit_i,
   output logic [HEX_W+1:0] acc_o,
   output logic             sat_o
);

   localparam int ACC_W  = HEX_W + 2;
   localparam int FULL_W = ACC_W + 4;

   logic [FULL_W-1:0] w_full;

   assign w_full = (FULL_W'(acc_i) << 3) + (FULL_W'(acc_i) << 1) + FULL_W'(digit_i);
   assign sat_o  = w_full > FULL_W'({HEX_W{1'b1}});
   // Clamp so a long entry cannot wrap the accumulator back below the limit
   assign acc_o  = (w_full > FULL_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

`default_nettype wire

// File: rtl/dec2hex_entry.sv
// ============================================================================
// dec2hex_entry : collects BCD digits (MSD first) and converts an entry to binary
// Revision      : 1.0
// ============================================================================
`default_nettype none

module dec2hex_entry
   import dec2hex_pkg::*;
#(
   parameter int MAX_DIGITS = MAX_DIGITS_DEF,
   parameter int HEX_W      = 8
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic [3:0]       digit,
   input  logic             digit_valid,
   output logic             digit_ready,
   input  logic             commit,
   input  logic             clear,
   output logic [HEX_W-1:0] hex,
   output logic             hex_valid,
   output logic             ovf,
   output logic             bad_digit,
   output logic [1:0]       digit_cnt
);

   localparam int         ACC_W   = HEX_W + 2;
   localparam logic [1:0] CNT_MAX = 2'(MAX_DIGITS);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [3:0]         dig_q, dig_d;
   logic               pend_q, pend_d;
   logic               esat_q, esat_d;
   logic               eovf_q, eovf_d;
   logic               ebad_q, ebad_d;
   logic [HEX_W-1:0]   hex_q, hex_d;
   logic               ovf_q, ovf_d;
   logic               bad_q, bad_d;

   logic [ACC_W-1:0]   w_mac_acc;
   logic               w_mac_sat;
   logic               w_ready;
   logic               w_xfer;
   logic               w_bad;
   logic               w_full;
   logic [HEX_W-1:0]   w_hex_new;
   logic               w_out_fire;

   dec2hex_mac #(.HEX_W(HEX_W)) u_mac (
      .acc_i   (acc_q),
      .digit_i (dig_q),
      .acc_o   (w_mac_acc),
      .sat_o   (w_mac_sat)
   );

   assign w_ready   = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
   assign w_xfer    = w_ready && digit_valid;
   assign w_bad     = digit >= DEC_BASE;
   assign w_full    = cnt_q == CNT_MAX;
   assign w_hex_new = esat_q ? {HEX_W{1'b1}} : acc_q[HEX_W-1:0];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         dig_q   <= '0;
         pend_q  <= 1'b0;
         esat_q  <= 1'b0;
         eovf_q  <= 1'b0;
         ebad_q  <= 1'b0;
         hex_q   <= '0;
         ovf_q   <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         pend_q  <= pend_d;
         esat_q  <= esat_d;
         eovf_q  <= eovf_d;
         ebad_q  <= ebad_d;
         hex_q   <= hex_d;
         ovf_q   <= ovf_d;
         bad_q   <= bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dig_d   = dig_q;
      pend_d  = pend_q;
      esat_d  = esat_q;
      eovf_d  = eovf_q;
      ebad_d  = ebad_q;
      hex_d   = hex_q;
      ovf_d   = ovf_q;
      bad_d   = bad_q;
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (w_xfer && !w_bad && !w_full) begin
               dig_d   = digit;
               pend_d  = commit;
               state_d = ST_CALC;
            end else if (w_xfer) begin
               // Rejected digits still complete the handshake; only the flag records them
               if (w_bad) ebad_d = 1'b1;
               else       eovf_d = 1'b1;
               state_d = commit ? ST_OUT : ST_COLLECT;
            end else if (commit) begin
               state_d = ST_OUT;
            end
         end
         ST_CALC: begin
            acc_d   = w_mac_acc;
            cnt_d   = cnt_q + 2'd1;
            esat_d  = esat_q | w_mac_sat;
            pend_d  = pend_q | commit;
            state_d = (pend_q || commit) ? ST_OUT : ST_COLLECT;
         end
         ST_OUT: begin
            hex_d   = w_hex_new;
            ovf_d   = esat_q | eovf_q;
            bad_d   = ebad_q;
            acc_d   = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
            esat_d  = 1'b0;
            eovf_d  = 1'b0;
            ebad_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         pend_d  = 1'b0;
         esat_d  = 1'b0;
         eovf_d  = 1'b0;
         ebad_d  = 1'b0;
         hex_d   = hex_q;
         ovf_d   = ovf_q;
         bad_d   = bad_q;
      end
   end

   // Result is presented combinationally during OUT so it coincides with hex_valid
   always_comb begin
      w_out_fire  = (state_q == ST_OUT) && !clear;
      digit_ready = w_ready;
      hex_valid   = w_out_fire;
      hex         = w_out_fire ? w_hex_new        : hex_q;
      ovf         = w_out_fire ? (esat_q | eovf_q) : ovf_q;
      bad_digit   = w_out_fire ? ebad_q           : bad_q;
      digit_cnt   = cnt_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_dec2hex_entry.sv
// ============================================================================
// tb_dec2hex_entry : directed self-checking bench for dec2hex_entry
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_dec2hex_entry;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       digit_valid = 1'b0;
   logic       digit_ready;
   logic       commit = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] hex;
   logic       hex_valid;
   logic       ovf;
   logic       bad_digit;
   logic [1:0] digit_cnt;

   int tests  = 0;
   int fails  = 0;
   int pulses = 0;

   dec2hex_entry #(.MAX_DIGITS(3), .HEX_W(8)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .digit       (digit),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .commit      (commit),
      .clear       (clear),
      .hex         (hex),
      .hex_valid   (hex_valid),
      .ovf         (ovf),
      .bad_digit   (bad_digit),
      .digit_cnt   (digit_cnt)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (hex_valid === 1'b1) pulses++;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (digit_ready !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      if (digit_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_ready: digit_ready=%b required 1 within 8 cycles", digit_ready);
      end
   endtask

   task automatic send(input logic [3:0] d, input logic c);
      wait_ready();
      digit = d; digit_valid = 1'b1; commit = c;
      step();
      digit_valid = 1'b0; commit = 1'b0;
   endtask

   task automatic do_commit();
      wait_ready();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      tests++; if (hex !== 8'h00 || hex_valid !== 1'b0 || ovf !== 1'b0 || bad_digit !== 1'b0 || digit_cnt !== 2'd0) begin
         fails++; $display("FAIL reset_outputs: hex=%h hv=%b ovf=%b bad=%b cnt=%0d required 00 0 0 0 0", hex, hex_valid, ovf, bad_digit, digit_cnt); end
      rst_n = 1'b1;
      step();
      tests++; if (digit_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", digit_ready); end
   endtask

   task automatic test_255();
      int p0 = pulses;
      send(4'd2, 1'b0); send(4'd5, 1'b0); send(4'd5, 1'b0);
      do_commit();
      tests++; if (hex_valid !== 1'b1 || hex !== 8'hFF || ovf !== 1'b0 || bad_digit !== 1'b0) begin
         fails++; $display("FAIL e255_out: hv=%b hex=%h ovf=%b bad=%b required 1 ff 0 0", hex_valid, hex, ovf, bad_digit); end
      step();
      tests++; if (hex_valid !== 1'b0 || hex !== 8'hFF || digit_cnt !== 2'd0) begin
         fails++; $display("FAIL e255_after: hv=%b hex=%h cnt=%0d required 0 ff 0", hex_valid, hex, digit_cnt); end
      tests++; if (pulses - p0 != 1) begin fails++; $display("FAIL e255_pulses: got %0d required 1", pulses - p0); end
   endtask

   task automatic test_256();
      send(4'd2, 1'b0); send(4'd5, 1'b0); send(4'd6, 1'b0);
      do_commit();
      tests++; if (hex !== 8'hFF || ovf !== 1'b1 || hex_valid !== 1'b1) begin
         fails++; $display("FAIL e256: hex=%h ovf=%b hv=%b required ff 1 1", hex, ovf, hex_valid); end
   endtask

   task automatic test_too_many();
      send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0);
      wait_ready();
      tests++; if (digit_cnt !== 2'd3) begin fails++; $display("FAIL e1234_cnt3: got %0d required 3", digit_cnt); end
      send(4'd4, 1'b0);
      tests++; if (digit_cnt !== 2'd3 || digit_ready !== 1'b1) begin
         fails++; $display("FAIL e1234_discard: cnt=%0d rdy=%b required 3 1", digit_cnt, digit_ready); end
      do_commit();
      tests++; if (hex !== 8'h7B || ovf !== 1'b1 || bad_digit !== 1'b0) begin
         fails++; $display("FAIL e1234_out: hex=%h ovf=%b bad=%b required 7b 1 0", hex, ovf, bad_digit); end
   endtask

   task automatic test_bad_digit();
      send(4'hA, 1'b0);
      tests++; if (digit_cnt !== 2'd0 || digit_ready !== 1'b1) begin
         fails++; $display("FAIL bad_discard: cnt=%0d rdy=%b required 0 1", digit_cnt, digit_ready); end
      send(4'd7, 1'b0);
      do_commit();
      tests++; if (hex !== 8'h07 || bad_digit !== 1'b1 || ovf !== 1'b0) begin
         fails++; $display("FAIL bad_out: hex=%h bad=%b ovf=%b required 07 1 0", hex, bad_digit, ovf); end
      send(4'd4, 1'b0); send(4'd2, 1'b0);
      do_commit();
      tests++; if (hex !== 8'h2A || bad_digit !== 1'b0 || ovf !== 1'b0) begin
         fails++; $display("FAIL clean_out: hex=%h bad=%b ovf=%b required 2a 0 0", hex, bad_digit, ovf); end
   endtask

   task automatic test_pending_commit();
      send(4'd4, 1'b0);
      send(4'd9, 1'b1);
      tests++; if (hex_valid !== 1'b0 || digit_ready !== 1'b0) begin
         fails++; $display("FAIL pend_calc: hv=%b rdy=%b required 0 0", hex_valid, digit_ready); end
      step();
      tests++; if (hex_valid !== 1'b1 || hex !== 8'h31) begin
         fails++; $display("FAIL pend_out: hv=%b hex=%h required 1 31", hex_valid, hex); end
      step();
   endtask

   task automatic test_empty_commit();
      do_commit();
      tests++; if (hex_valid !== 1'b1 || hex !== 8'h00 || ovf !== 1'b0 || bad_digit !== 1'b0) begin
         fails++; $display("FAIL empty_out: hv=%b hex=%h ovf=%b bad=%b required 1 00 0 0", hex_valid, hex, ovf, bad_digit); end
      step();
      send(4'hF, 1'b1);
      tests++; if (hex_valid !== 1'b1 || hex !== 8'h00 || bad_digit !== 1'b1 || ovf !== 1'b0) begin
         fails++; $display("FAIL empty_bad: hv=%b hex=%h bad=%b ovf=%b required 1 00 1 0", hex_valid, hex, bad_digit, ovf); end
      step();
   endtask

   task automatic test_clear();
      int p0;
      send(4'd4, 1'b0); send(4'd9, 1'b0);
      do_commit();
      step();
      p0 = pulses;
      send(4'd8, 1'b0); send(4'd8, 1'b0);
      wait_ready();
      tests++; if (digit_cnt !== 2'd2) begin fails++; $display("FAIL clr_pre: cnt=%0d required 2", digit_cnt); end
      clear = 1'b1; commit = 1'b1;
      step();
      clear = 1'b0; commit = 1'b0;
      step(); step();
      tests++; if (digit_cnt !== 2'd0 || hex !== 8'h31 || hex_valid !== 1'b0) begin
         fails++; $display("FAIL clr_post: cnt=%0d hex=%h hv=%b required 0 31 0", digit_cnt, hex, hex_valid); end
      tests++; if (pulses != p0) begin fails++; $display("FAIL clr_pulses: got %0d required 0", pulses - p0); end
   endtask

   task automatic test_reset_mid_calc();
      send(4'd5, 1'b0);
      rst_n = 1'b0;
      #1;
      tests++; if (hex !== 8'h00 || hex_valid !== 1'b0 || ovf !== 1'b0 || bad_digit !== 1'b0 || digit_cnt !== 2'd0 || digit_ready !== 1'b1) begin
         fails++; $display("FAIL rst_calc: hex=%h hv=%b ovf=%b bad=%b cnt=%0d rdy=%b required 00 0 0 0 0 1", hex, hex_valid, ovf, bad_digit, digit_cnt, digit_ready); end
      step();
      rst_n = 1'b1;
      step();
      tests++; if (digit_ready !== 1'b1 || hex_valid !== 1'b0) begin
         fails++; $display("FAIL rst_release: rdy=%b hv=%b required 1 0", digit_ready, hex_valid); end
   endtask

   initial begin
      test_reset();
      test_255();
      test_256();
      test_too_many();
      test_bad_digit();
      test_pending_commit();
      test_empty_commit();
      test_clear();
      test_reset_mid_calc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dec2hex_entry.md
DEC2HEX_ENTRY -- requirements
Module: dec2hex_entry

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, max decimal digits accepted per entry.
REQ-002 SHALL have parameter HEX_W, default 8, width of binary result.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port digit  input  4  BCD digit, most significant digit first.
REQ-006 SHALL have port digit_valid  input  1  digit present; transfers when digit_valid & digit_ready.
REQ-007 SHALL have port digit_ready  output  1  block can accept a digit or commit this cycle.
REQ-008 SHALL have port commit  input  1  end of entry; honoured only when digit_ready=1, else stored as pending (REQ-017).
REQ-009 SHALL have port clear  input  1  synchronous abort of current entry.
REQ-010 SHALL have port hex  output  HEX_W  binary result of last committed entry.
REQ-011 SHALL have port hex_valid  output  1  one-cycle pulse when hex updates.
REQ-012 SHALL have port ovf  output  1  last committed entry exceeded 2^HEX_W-1 or had too many digits.
REQ-013 SHALL have port bad_digit  output  1  last committed entry contained a digit > 9.
REQ-014 SHALL have port digit_cnt  output  2  digits accumulated in current entry (0..MAX_DIGITS).

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, CALC, OUT; IDLE/COLLECT drive digit_ready=1, CALC/OUT drive 0.
REQ-016 SHALL, on digit transfer, enter CALC for exactly one cycle, computing acc = acc*10 + digit in HEX_W+2 bits, then go to COLLECT; digit_ready is high again 2 cycles after transfer.
REQ-017 SHALL, if commit and a digit transfer occur in the same cycle, accept the digit first, set a pending-commit flag, and perform the commit at the end of CALC (CALC->OUT).
REQ-018 SHALL, on commit in IDLE/COLLECT, go to OUT next cycle; in OUT, hex, ovf and bad_digit update and hex_valid=1 for exactly one cycle; the following cycle returns to IDLE with acc=0, digit_cnt=0 and entry flags cleared.
REQ-019 SHALL saturate hex to 2^HEX_W-1 and set ovf when acc exceeds 2^HEX_W-1 (e.g. 256..999).
REQ-020 SHALL complete the handshake for a digit > 9 but discard it (acc and digit_cnt unchanged, no CALC) and set the entry's bad_digit flag.
REQ-021 SHALL complete the handshake for a digit arriving when digit_cnt = MAX_DIGITS, discard it, and set the entry's ovf flag.
REQ-022 SHALL, on commit with digit_cnt=0, output hex=0 with hex_valid, ovf and bad_digit reflecting only discarded digits of that entry.
REQ-023 SHALL give clear priority over digit and commit in every state: next state IDLE, acc=0, digit_cnt=0, pending/entry flags=0, no hex_valid; hex, ovf, bad_digit keep last committed values.
REQ-024 SHALL hold hex, ovf and bad_digit stable between hex_valid pulses.

Reset
REQ-025 SHALL, while rst_n=0, force state IDLE, acc=0, hex=0, hex_valid=0, ovf=0, bad_digit=0, digit_cnt=0, pending commit=0; digit_ready=1 on the first cycle after release.
REQ-026 SHALL abandon any in-progress entry on reset without producing hex_valid.

Structure
REQ-027 SHALL place FSM state typedef, MAX_DIGITS default, and decimal constant 10 in shared package dec2hex_pkg.
REQ-028 SHALL use one sub-module, dec2hex_mac: combinational acc*10+digit via (acc<<3)+(acc<<1)+digit, plus saturation compare.

Verification
REQ-029 SHALL verify digits 2,5,5 then commit -> hex=0xFF, ovf=0, bad_digit=0, single-cycle hex_valid.
REQ-030 SHALL verify digits 2,5,6 then commit -> hex=0xFF, ovf=1.
REQ-031 SHALL verify digits 1,2,3,4 then commit -> 4th discarded, hex=0x7B, ovf=1, digit_cnt peaks at 3.
REQ-032 SHALL verify digit 0xA, then 7, then commit -> hex=0x07, bad_digit=1; following clean entry 4,2 -> hex=0x2A, bad_digit=0.
REQ-033 SHALL verify digit 4, then digit 9 with commit in the same cycle -> hex=0x31, hex_valid 2 cycles after that transfer.
REQ-034 SHALL verify clear after digits 8,8 -> no hex_valid, hex keeps prior value, digit_cnt=0; also rst_n low mid-CALC -> all outputs at reset values.
